// File: rtl/board_reset_ctrl_pkg.sv
// Shared types and constants for the board reset sequencer and button conditioners.
package board_ctrl_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } rst_state_e;

    function automatic logic sync_tap(input logic [SYNC_STAGES-1:0] chain);
        return chain[SYNC_STAGES-1];
    endfunction

endpackage

// File: rtl/board_reset_ctrl_if.sv
// Button bundle between board pins and the reset controller; names are seen from the controller side.
interface board_reset_ctrl_if #(
    parameter int unsigned NUM_BTNS = 7
);
    logic [NUM_BTNS-1:0] btn_i;
    logic [NUM_BTNS-1:0] btn_o;
    logic [NUM_BTNS-1:0] btn_press_o;
    logic [NUM_BTNS-1:0] btn_release_o;
    logic [NUM_BTNS-1:0] btn_long_o;

    modport master (
        output btn_i,
        input  btn_o, btn_press_o, btn_release_o, btn_long_o
    );

    modport slave (
        input  btn_i,
        output btn_o, btn_press_o, btn_release_o, btn_long_o
    );
endinterface

// File: rtl/board_reset_ctrl_btn_debounce.sv
// One button channel: synchroniser, polarity fix, debounce, press/release strobes.
// Long-press strobe only when BTN_LONG_PRESS_EN is defined.
module btn_debounce
    import board_ctrl_pkg::*;
#(
    parameter logic        ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 16
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_CYCLES     = 1000000
`endif
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;

    assign sample_s = sync_tap(sync_q) ^ ACTIVE_LOW;

    // Pin synchroniser
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    // Debounce next-state: a level change needs DEBOUNCE_CYCLES differing samples in a row
    always_comb begin
        cnt_d   = {CW{1'b0}};
        lvl_d   = lvl_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sample_s == lvl_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            lvl_d   = ~lvl_q;
            press_d = ~lvl_q;
            rel_d   = lvl_q;
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
    end

    // Debounce state and strobe registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q   <= {CW{1'b0}};
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign btn_o     = lvl_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned   HW        = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Hold counter saturates past the strobe point so the strobe fires once per press
    always_comb begin
        hold_d = hold_q;
        long_d = lvl_q && (hold_q == HOLD_LAST);
        if (!lvl_q) begin
            hold_d = {HW{1'b0}};
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1'b1);
        end else begin
            hold_d = hold_q;
        end
    end

    // Hold counter and long-press strobe registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_q <= {HW{1'b0}};
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/board_reset_ctrl.sv
// Board reset sequencer: lock synchroniser, POR hold FSM and per-button conditioners.
// Optional long-press strobes are enabled with the BTN_LONG_PRESS_EN macro.
module board_reset_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int unsigned         NUM_BTNS        = 7,
    parameter logic [NUM_BTNS-1:0] BTN_ACTIVE_LOW  = {NUM_BTNS{1'b1}},
    parameter int unsigned         RESET_BTN_IDX   = 0,
    parameter int unsigned         DEBOUNCE_CYCLES = 16,
    parameter int unsigned         POR_CYCLES      = 31
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int unsigned         LONG_CYCLES     = 1000000
`endif
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic               pll_locked_i,
    output logic               reset_o,
    board_reset_ctrl_if.slave  btn_if
);
    localparam int unsigned   PW       = $clog2(POR_CYCLES + 1);
    localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [NUM_BTNS-1:0]    lvl_s, press_s, rel_s, long_s;
    logic                   hold_req_s;
    rst_state_e             state_q, state_d;
    logic [PW-1:0]          por_q, por_d;
    logic                   reset_q, reset_d;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_debounce #(
            .ACTIVE_LOW      (BTN_ACTIVE_LOW[g]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_LONG_PRESS_EN
            ,
            .LONG_CYCLES     (LONG_CYCLES)
`endif
        ) u_debounce (
            .clk       (clk),
            .reset_n_i (reset_n_i),
            .btn_i     (btn_if.btn_i[g]),
            .btn_o     (lvl_s[g]),
            .press_o   (press_s[g]),
            .release_o (rel_s[g]),
            .long_o    (long_s[g])
        );
    end

    assign btn_if.btn_o         = lvl_s;
    assign btn_if.btn_press_o   = press_s;
    assign btn_if.btn_release_o = rel_s;
    assign btn_if.btn_long_o    = long_s;

    // Lost lock and a held reset button are equivalent reasons to hold the core
    assign hold_req_s = !sync_tap(lock_sync_q) || lvl_s[RESET_BTN_IDX];

    // State, POR counter, lock synchroniser and reset output registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_sync_q <= {SYNC_STAGES{1'b0}};
            state_q     <= HOLD;
            por_q       <= {PW{1'b0}};
            reset_q     <= 1'b1;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
            state_q     <= state_d;
            por_q       <= por_d;
            reset_q     <= reset_d;
        end
    end

    // Next-state logic; the POR counter stops at its last value instead of wrapping
    always_comb begin
        state_d = state_q;
        por_d   = por_q;
        case (state_q)
            HOLD: begin
                por_d = {PW{1'b0}};
                if (!hold_req_s) begin
                    state_d = COUNT;
                end else begin
                    state_d = HOLD;
                end
            end
            COUNT: begin
                if (hold_req_s) begin
                    state_d = HOLD;
                    por_d   = {PW{1'b0}};
                end else if (por_q == POR_LAST) begin
                    state_d = RUN;
                end else begin
                    por_d = por_q + PW'(1'b1);
                end
            end
            RUN: begin
                if (hold_req_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = HOLD;
                por_d   = {PW{1'b0}};
            end
        endcase
    end

    // Output decode, registered above
    always_comb begin
        reset_d = (state_q != RUN);
    end

    assign reset_o = reset_q;

endmodule

// File: tb/tb_board_reset_ctrl.sv
// Randomised bench for board_reset_ctrl against a streak/window reference model.
module tb_board_reset_ctrl;

    localparam int              NB    = 7;
    localparam logic [NB-1:0]   MASK  = 7'b1011101;
    localparam int              DEB   = 16;
    localparam int              POR   = 31;
    localparam int              LONG  = 100;

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic            pll_locked_i;
    logic            reset_o;

    board_reset_ctrl_if #(.NUM_BTNS(NB)) btn_if ();

    board_reset_ctrl #(
        .NUM_BTNS        (NB),
        .BTN_ACTIVE_LOW  (MASK),
        .RESET_BTN_IDX   (0),
        .DEBOUNCE_CYCLES (DEB),
        .POR_CYCLES      (POR)
`ifdef BTN_LONG_PRESS_EN
        ,
        .LONG_CYCLES     (LONG)
`endif
    ) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .pll_locked_i (pll_locked_i),
        .reset_o      (reset_o),
        .btn_if       (btn_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // stimulus state (logical: 1 = pressed)
    logic [NB-1:0] pressed;
    logic          lock_pin;

    // reference model state
    logic [NB-1:0]  pin_d1, pin_d2;
    logic           lock_d1, lock_d2;
    logic [NB-1:0]  m_lvl, m_press, m_rel, m_long;
    logic [DEB-1:0] m_hist [NB];
    int             m_held [NB];
    int             m_streak;
    logic           m_run, m_reset;

    int press3_cnt, long2_cnt, rel2_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    function automatic void model_reset();
        pin_d1 = '0; pin_d2 = '0; lock_d1 = 1'b0; lock_d2 = 1'b0;
        m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
        for (int c = 0; c < NB; c++) begin
            m_hist[c] = '0;
            m_held[c] = 0;
        end
        m_streak = 0; m_run = 1'b0; m_reset = 1'b1;
    endfunction

    // One clock edge of the reference: samples lag the pins by two edges
    function automatic void model_step(input logic [NB-1:0] pins, input logic lock_now);
        logic [NB-1:0] samp;
        logic          nl;
        samp = pin_d2 ^ MASK;
        // reset: core runs once POR+1 consecutive edges saw lock with the button up
        m_reset = !m_run;
        if (lock_d2 && !m_lvl[0]) begin
            if (m_streak <= POR) m_streak++;
        end else begin
            m_streak = 0;
        end
        m_run = (m_streak >= POR + 1);
        for (int c = 0; c < NB; c++) begin
            m_hist[c] = {m_hist[c][DEB-2:0], samp[c]};
            nl = m_lvl[c];
            if (m_hist[c] == {DEB{~m_lvl[c]}}) nl = ~m_lvl[c];
            m_press[c] = nl & ~m_lvl[c];
            m_rel[c]   = ~nl & m_lvl[c];
`ifdef BTN_LONG_PRESS_EN
            m_long[c] = m_lvl[c] && (m_held[c] == LONG - 1);
            if (!m_lvl[c]) m_held[c] = 0;
            else if (m_held[c] < LONG) m_held[c]++;
`else
            m_long[c] = 1'b0;
`endif
            m_lvl[c] = nl;
        end
        pin_d2 = pin_d1; pin_d1 = pins;
        lock_d2 = lock_d1; lock_d1 = lock_now;
    endfunction

    task automatic compare_all();
        check("reset_o",       {31'd0, reset_o},             {31'd0, m_reset});
        check("btn_o",         {25'd0, btn_if.btn_o},         {25'd0, m_lvl});
        check("btn_press_o",   {25'd0, btn_if.btn_press_o},   {25'd0, m_press});
        check("btn_release_o", {25'd0, btn_if.btn_release_o}, {25'd0, m_rel});
        check("btn_long_o",    {25'd0, btn_if.btn_long_o},    {25'd0, m_long});
    endtask

    task automatic tick();
        logic [NB-1:0] pins;
        pins = pressed ^ MASK;
        btn_if.btn_i = pins;
        pll_locked_i = lock_pin;
        @(posedge clk);
        model_step(pins, lock_pin);
        #1;
        cycle++;
        if (btn_if.btn_press_o[3]) press3_cnt++;
        if (btn_if.btn_long_o[2]) long2_cnt++;
        if (btn_if.btn_release_o[2]) rel2_cnt++;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called just after a compare; exercises immediate async assertion
    task automatic async_reset();
        reset_n_i = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2;
        reset_n_i = 1'b1;
    endtask

    int hold_left [NB];
    int lock_left;

    initial begin
        reset_n_i    = 1'b0;
        pressed      = '0;
        lock_pin     = 1'b1;
        btn_if.btn_i = MASK;
        pll_locked_i = 1'b1;
        press3_cnt = 0; long2_cnt = 0; rel2_cnt = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        #2;
        reset_n_i = 1'b1;

        // power-up with lock present and all buttons released
        ticks(60);
        check("run_after_por", {31'd0, reset_o}, 32'd0);

        // bouncing press on an active-low button: exactly one press strobe
        press3_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            pressed[3] = 1'b1; ticks(5);
            pressed[3] = 1'b0; ticks(5);
        end
        pressed[3] = 1'b1; ticks(40);
        check("btn3_press_count", press3_cnt, 32'd1);
        check("btn3_level", {31'd0, btn_if.btn_o[3]}, 32'd1);
        pressed[3] = 1'b0; ticks(40);

        // reset button in RUN, then release and full re-sequence
        pressed[0] = 1'b1; ticks(40);
        check("reset_on_button", {31'd0, reset_o}, 32'd1);
        pressed[0] = 1'b0; ticks(40);

        // lock drop during COUNT restarts the POR count
        lock_pin = 1'b0; ticks(10);
        lock_pin = 1'b1; ticks(20);
        check("reset_held_after_glitch", {31'd0, reset_o}, 32'd1);
        ticks(30);

        // long hold on button 2
        long2_cnt = 0; rel2_cnt = 0;
        pressed[2] = 1'b1; ticks(250);
        pressed[2] = 1'b0; ticks(40);
`ifdef BTN_LONG_PRESS_EN
        check("btn2_long_count", long2_cnt, 32'd1);
`else
        check("btn2_long_count", long2_cnt, 32'd0);
`endif
        check("btn2_release_count", rel2_cnt, 32'd1);

        // randomised soak with two mid-run async resets
        for (int c = 0; c < NB; c++) hold_left[c] = 0;
        lock_left = 100;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold_left[c] == 0) begin
                    if (c == 0) begin
                        pressed[0]   = ($urandom_range(0, 3) == 0);
                        hold_left[0] = $urandom_range(20, 400);
                    end else begin
                        pressed[c]   = $urandom_range(0, 1) == 1;
                        hold_left[c] = $urandom_range(1, 40);
                    end
                end else begin
                    hold_left[c]--;
                end
            end
            if (lock_left == 0) begin
                lock_pin  = ~lock_pin;
                lock_left = lock_pin ? $urandom_range(50, 600) : $urandom_range(1, 14);
            end else begin
                lock_left--;
            end
            tick();
            if (cyc == 1500 || cyc == 3000) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
